uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_tx_if.sv | 9 +
 rtl/uart_tx_parity.sv | 27 ++
 rtl/uart_tx.sv | 156 +++++++++++++++
 tb/tb_uart_tx.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, word-length codes and bit timing.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int TICKS_PER_BIT = 16;
    localparam logic [4:0] BIT_TICKS_LAST = 5'(TICKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    typedef enum logic [1:0] {
        WLS_5 = 2'b00,
        WLS_6 = 2'b01,
        WLS_7 = 2'b10,
        WLS_8 = 2'b11
    } uart_wls_t;

    // Final tick value for the stop period: 1, 2 or (5-bit words only) 1.5 bit times.
    function automatic logic [4:0] stop_ticks_last(input logic stb, input logic [1:0] wls);
        if (!stb)
            return 5'(TICKS_PER_BIT - 1);
        else if (wls == WLS_5)
            return 5'(TICKS_PER_BIT + TICKS_PER_BIT / 2 - 1);
        else
            return 5'(2 * TICKS_PER_BIT - 1);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// FIFO-head handshake between the TX FIFO (master) and the transmitter (slave).
interface uart_tx_if;
    logic       fifo_empty;
    logic [7:0] din;
    logic       pop;

    modport master (output fifo_empty, output din, input pop);
    modport slave  (input fifo_empty, input din, output pop);
endinterface

// File: rtl/uart_tx_parity.sv
// Combinational parity over the 5..8 active data bits; shared with receive-side checking.
module uart_tx_parity
    import uart_pkg::*;
(
    input  logic [7:0] data,
    input  logic [1:0] wls,
    input  logic       eps,
    input  logic       sticky_parity,
    output logic       parity
);

    logic [7:0] masked;

    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
        assign masked[gi] = data[gi] && (int'(wls) + 5 > gi);
    end

    always_comb begin
        case ({sticky_parity, eps})
            2'b00:   parity = ~^masked;
            2'b01:   parity = ^masked;
            2'b10:   parity = 1'b1;
            default: parity = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: frames FIFO bytes at 16 baud pulses per bit (start, data, parity, stop).
// Optional macro UART_TX_BREAK_EN lets set_break hold the line low.
module uart_tx
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_pulse,
    uart_tx_if.slave   fifo,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       eps,
    input  logic       sticky_parity,
    input  logic       set_break,
    output logic       tx,
    output logic       temt
);

    uart_state_t state_reg, state_next;
    logic [4:0]  tick_reg, tick_next;
    logic [2:0]  bitcnt_reg, bitcnt_next;
    logic [7:0]  shift_reg, shift_next;
    logic        parity_reg, parity_next;
    logic [1:0]  wls_reg, wls_next;
    logic        stb_reg, stb_next;
    logic        pen_reg, pen_next;
    logic        parity_calc;
    logic        pop_next;
    logic        line;

    uart_tx_parity parity_gen (
        .data          (fifo.din),
        .wls           (wls),
        .eps           (eps),
        .sticky_parity (sticky_parity),
        .parity        (parity_calc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            tick_reg   <= '0;
            bitcnt_reg <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            wls_reg    <= '0;
            stb_reg    <= 1'b0;
            pen_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            tick_reg   <= tick_next;
            bitcnt_reg <= bitcnt_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            wls_reg    <= wls_next;
            stb_reg    <= stb_next;
            pen_reg    <= pen_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        tick_next   = tick_reg;
        bitcnt_next = bitcnt_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        wls_next    = wls_reg;
        stb_next    = stb_reg;
        pen_next    = pen_reg;
        pop_next    = 1'b0;

        if (baud_pulse) begin
            case (state_reg)
                ST_IDLE: begin
                    // Frame configuration and parity are captured here and frozen for the frame.
                    if (!fifo.fifo_empty) begin
                        pop_next    = 1'b1;
                        shift_next  = fifo.din;
                        parity_next = parity_calc;
                        wls_next    = wls;
                        stb_next    = stb;
                        pen_next    = pen;
                        bitcnt_next = 3'd4 + 3'(wls);
                        tick_next   = BIT_TICKS_LAST;
                        state_next  = ST_START;
                    end
                end
                ST_START: begin
                    if (tick_reg == 5'd0) begin
                        tick_next  = BIT_TICKS_LAST;
                        state_next = ST_DATA;
                    end else begin
                        tick_next = tick_reg - 5'd1;
                    end
                end
                ST_DATA: begin
                    if (tick_reg == 5'd0) begin
                        tick_next  = BIT_TICKS_LAST;
                        shift_next = shift_reg >> 1;
                        if (bitcnt_reg == 3'd0) begin
                            if (pen_reg) begin
                                state_next = ST_PARITY;
                            end else begin
                                state_next = ST_STOP;
                                tick_next  = stop_ticks_last(stb_reg, wls_reg);
                            end
                        end else begin
                            bitcnt_next = bitcnt_reg - 3'd1;
                        end
                    end else begin
                        tick_next = tick_reg - 5'd1;
                    end
                end
                ST_PARITY: begin
                    if (tick_reg == 5'd0) begin
                        state_next = ST_STOP;
                        tick_next  = stop_ticks_last(stb_reg, wls_reg);
                    end else begin
                        tick_next = tick_reg - 5'd1;
                    end
                end
                ST_STOP: begin
                    if (tick_reg == 5'd0) begin
                        state_next = ST_IDLE;
                    end else begin
                        tick_next = tick_reg - 5'd1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (state_reg)
            ST_START:  line = 1'b0;
            ST_DATA:   line = shift_reg[0];
            ST_PARITY: line = parity_reg;
            default:   line = 1'b1;
        endcase
    end

    assign fifo.pop = pop_next;
    assign temt     = (state_reg == ST_IDLE);

`ifdef UART_TX_BREAK_EN
    // Break overrides only the pin; the frame keeps its normal timing underneath.
    assign tx = line & ~set_break;
`else
    logic unused_set_break;
    assign unused_set_break = set_break;
    assign tx = line;
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: stimulus queues expected frames, a monitor checks the line per baud pulse.
`timescale 1ns/1ps
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_pulse = 1'b0;
    logic [1:0] wls = 2'b11;
    logic       stb = 1'b0;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sticky_parity = 1'b0;
    logic       set_break = 1'b0;
    logic       tx;
    logic       temt;

    uart_tx_if fifo_bus ();

    uart_tx dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .baud_pulse    (baud_pulse),
        .fifo          (fifo_bus),
        .wls           (wls),
        .stb           (stb),
        .pen           (pen),
        .eps           (eps),
        .sticky_parity (sticky_parity),
        .set_break     (set_break),
        .tx            (tx),
        .temt          (temt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        int          nbits;        // start + data + optional parity
        logic [11:0] bits;         // line level per bit slot, slot 0 = start
        int          stop_pulses;
    } frame_t;

    frame_t     sb[$];
    logic [7:0] fifo_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;
    int exp_pops = 0;
    bit baud_en    = 1'b0;
    bit fixed_rate = 1'b1;
    bit brk_mode   = 1'b0;
    bit in_frame   = 1'b0;
    int mon_j      = 0;

    // Reference frame built straight from the framing rules.
    function automatic frame_t model(input logic [7:0] d, input logic [1:0] w, input logic s,
                                     input logic p, input logic e, input logic st);
        frame_t f;
        int nd;
        int ones;
        nd = 5 + int'(w);
        ones = 0;
        f.data = d;
        f.bits = '0;
        f.bits[0] = 1'b0;
        for (int i = 0; i < nd; i++) begin
            f.bits[i + 1] = d[i];
            ones += int'(d[i]);
        end
        f.nbits = 1 + nd;
        if (p) begin
            if (st)     f.bits[f.nbits] = ~e;
            else if (e) f.bits[f.nbits] = (ones % 2 == 1);
            else        f.bits[f.nbits] = (ones % 2 == 0);
            f.nbits++;
        end
        if (!s)          f.stop_pulses = 16;
        else if (w == 0) f.stop_pulses = 24;
        else             f.stop_pulses = 32;
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Baud pulse source: fixed 1-in-4 clocks or random spacing.
    initial begin
        int gap;
        gap = 0;
        forever begin
            @(posedge clk);
            #2;
            if (baud_en && gap == 0) begin
                baud_pulse = 1'b1;
                gap = fixed_rate ? 3 : $urandom_range(0, 3);
            end else begin
                baud_pulse = 1'b0;
                if (gap > 0) gap--;
            end
        end
    end

    // FIFO model: head presented on din, removed after a pop edge.
    initial begin
        logic pop_seen;
        fifo_bus.fifo_empty = 1'b1;
        fifo_bus.din = 8'h00;
        forever begin
            @(negedge clk);
            pop_seen = fifo_bus.pop;
            @(posedge clk);
            #2;
            if (pop_seen === 1'b1 && rst_n && fifo_q.size() > 0) fifo_q.delete(0);
            fifo_bus.fifo_empty = (fifo_q.size() == 0);
            fifo_bus.din = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
        end
    end

    // Break toggling when enabled for a frame.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (brk_mode) begin
                if ($urandom_range(0, 15) == 0) set_break = ~set_break;
            end else begin
                set_break = 1'b0;
            end
        end
    end

    // Monitor: samples after every baud-pulse edge and compares against the scoreboard.
    initial begin
        bit     pend;
        bit     rogue;
        frame_t cur;
        int     slot_bad;
        bit     temt_bad;
        int     total;
        logic   req;
        logic   last_act;
        logic   last_req;
        pend = 1'b0;
        rogue = 1'b0;
        slot_bad = 0;
        temt_bad = 1'b0;
        last_act = 1'b0;
        last_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0;
                rogue = 1'b0;
                pend = 1'b0;
                continue;
            end
            if (pend) begin
                if (rogue && temt === 1'b1) rogue = 1'b0;
                if (!in_frame && !rogue && temt === 1'b0) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        rogue = 1'b1;
                        $display("FAIL unexpected_frame: temt=0 with no frame queued, required temt=1");
                    end else begin
                        cur = sb.pop_front();
                        in_frame = 1'b1;
                        mon_j = 0;
                        slot_bad = 0;
                        temt_bad = 1'b0;
                    end
                end
                if (in_frame) begin
                    total = cur.nbits * 16 + cur.stop_pulses;
                    if (mon_j < total) begin
                        req = (mon_j < cur.nbits * 16) ? cur.bits[mon_j / 16] : 1'b1;
`ifdef UART_TX_BREAK_EN
                        if (set_break) req = 1'b0;
`endif
                        if (tx !== req) begin
                            slot_bad++;
                            last_act = tx;
                            last_req = req;
                        end
                        if (temt !== 1'b0) temt_bad = 1'b1;
                        if ((mon_j < cur.nbits * 16 && mon_j % 16 == 15) || mon_j == total - 1) begin
                            n_checks++;
                            if (slot_bad != 0) begin
                                n_fail++;
                                $display("FAIL frame %02h slot %0d: %0d samples tx=%b, required tx=%b",
                                         cur.data, mon_j / 16, slot_bad, last_act, last_req);
                            end
                            slot_bad = 0;
                        end
                    end else begin
                        n_checks++;
                        if (temt !== 1'b1 || temt_bad) begin
                            n_fail++;
                            $display("FAIL frame %02h end: temt=%b at pulse %0d (early rise %0d), required temt=1 exactly at pulse %0d",
                                     cur.data, temt, mon_j, temt_bad, total);
                        end
                        in_frame = 1'b0;
                    end
                    mon_j++;
                end else if (!rogue) begin
                    req = 1'b1;
`ifdef UART_TX_BREAK_EN
                    if (set_break) req = 1'b0;
`endif
                    check("idle_tx", 32'(tx), 32'(req));
                end
            end
            if (fifo_bus.pop === 1'b1) begin
                n_pops++;
                check("pop_legal", {29'd0, baud_pulse, fifo_bus.fifo_empty, temt}, 32'b101);
            end
            pend = baud_pulse;
        end
    end

    task automatic enqueue(input logic [7:0] d);
        fifo_q.push_back(d);
        sb.push_back(model(d, wls, stb, pen, eps, sticky_parity));
        exp_pops++;
    endtask

    // Drain queued bytes, disturb the configuration mid-frame, then wait for the line to settle.
    task automatic finish_frames(input string name);
        int budget;
        budget = 6000;
        while (fifo_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        check({name, "_pop_timeout"}, 32'(fifo_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        wls = 2'($urandom);
        stb = 1'($urandom);
        pen = 1'($urandom);
        eps = 1'($urandom);
        sticky_parity = 1'($urandom);
        budget = 6000;
        while ((sb.size() != 0 || in_frame) && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        check({name, "_done_timeout"}, 32'(sb.size() + int'(in_frame)), 32'd0);
        check({name, "_pop_count"}, 32'(n_pops), 32'(exp_pops));
        brk_mode = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] w, input logic s, input logic p, input logic e, input logic st);
        wls = w;
        stb = s;
        pen = p;
        eps = e;
        sticky_parity = st;
    endtask

    initial begin
        int budget;
        int pops_before;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_temt", 32'(temt), 32'd1);
        check("reset_pop", 32'(fifo_bus.pop), 32'd0);
        #1;
        rst_n = 1'b1;

        // 0x55, 8N1, fixed rate; nothing may happen before the first baud pulse.
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        enqueue(8'h55);
        repeat (10) @(negedge clk);
        check("no_action_before_pulse", {30'd0, temt, fifo_bus.pop}, 32'b10);
        #1;
        baud_en = 1'b1;
        finish_frames("h55_8n1");

        // Parity modes on 0x07.
        for (int m = 0; m < 4; m++) begin
            @(negedge clk);
            #1;
            set_cfg(2'b11, 1'b0, 1'b1, m[0], m[1]);
            enqueue(8'h07);
            finish_frames($sformatf("h07_par%0d", m));
        end

        // 5-bit word with 1.5 stop bits.
        @(negedge clk);
        #1;
        set_cfg(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        enqueue(8'hFF);
        finish_frames("hFF_5bit_1p5stop");

        // Back-to-back queued bytes.
        @(negedge clk);
        #1;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        enqueue(8'hA3);
        enqueue(8'h3C);
        finish_frames("back_to_back");

        // Break activity during a frame.
        @(negedge clk);
        #1;
        set_cfg(2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        brk_mode = 1'b1;
        enqueue(8'h5A);
        finish_frames("break_frame");

        // Randomised frames, rates and configurations.
        for (int r = 0; r < 14; r++) begin
            int nb;
            @(negedge clk);
            #1;
            fixed_rate = 1'($urandom);
            set_cfg(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            brk_mode = ($urandom_range(0, 3) == 0);
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) enqueue(8'($urandom));
            finish_frames($sformatf("rand%0d", r));
        end

        // Reset in the middle of data bit 3.
        @(negedge clk);
        #1;
        fixed_rate = 1'b1;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        enqueue(8'hC6);
        budget = 6000;
        while (!(in_frame && mon_j >= 72) && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        check("midframe_reach_timeout", 32'(in_frame && mon_j >= 72), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_temt", 32'(temt), 32'd1);
        check("midrst_pop", 32'(fifo_bus.pop), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        pops_before = n_pops;
        repeat (200) @(negedge clk);
        check("post_rst_pop", 32'(n_pops), 32'(pops_before));
        check("post_rst_tx", 32'(tx), 32'd1);
        check("post_rst_temt", 32'(temt), 32'd1);

        check("final_scoreboard", 32'(sb.size()), 32'd0);
        check("final_pops", 32'(n_pops), 32'(exp_pops));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

endmodule
